// File: rtl/pet_loader_pkg.sv
// Shared types and constants for the PET download loader.
// PRG_AUTORUN_EN adds the keyboard-buffer autorun state and its string.
package pet_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PRG_HDR,
        ST_PRG_DATA,
        ST_ROM_DATA,
        ST_WR_PEND,
        ST_FIX_LO,
        ST_FIX_HI,
`ifdef PRG_AUTORUN_EN
        ST_AUTORUN,
`endif
        ST_DONE
    } state_t;

    localparam logic [15:0] KBD_BUF_ADDR = 16'h026F;
    localparam logic [15:0] KBD_CNT_ADDR = 16'h009E;
    localparam logic [24:0] ROM_LO       = 25'h0400;
    localparam logic [24:0] ROM_HI       = 25'h8000;
    localparam logic [15:0] ROM_OFS      = 16'h8000;

`ifdef PRG_AUTORUN_EN
    // "RUN" + CR typed into the keyboard buffer; count goes to KBD_CNT_ADDR.
    localparam logic [7:0] AUTORUN_STR [0:3] = '{8'h52, 8'h55, 8'h4E, 8'h0D};
    localparam logic [7:0] KBD_CNT_VAL       = 8'h04;
`endif

endpackage

// File: rtl/dma_write_slot.sv
// Single-entry DMA write holder: captures addr/data on issue and keeps
// dma_we asserted until the memory side accepts with dma_ready.
module dma_write_slot (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue,
    input  logic [15:0] issue_addr,
    input  logic [7:0]  issue_data,
    input  logic        dma_ready,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    output logic        idle
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dma_addr <= 16'h0000;
            dma_din  <= 8'h00;
            dma_we   <= 1'b0;
        end else if (issue) begin
            dma_addr <= issue_addr;
            dma_din  <= issue_data;
            dma_we   <= 1'b1;
        end else if (dma_we && dma_ready) begin
            dma_we   <= 1'b0;
        end
    end

    assign idle = !dma_we;

endmodule

// File: rtl/prg_dma_loader.sv
// Sequences OSD PRG/ROM downloads into PET memory through a handshaked DMA
// slot, then patches VARTAB. PRG_AUTORUN_EN also queues "RUN" in the keyboard buffer.
module prg_dma_loader
    import pet_loader_pkg::*;
#(
    parameter logic [7:0]  PRG_INDEX = 8'h41,
    parameter logic [7:0]  ROM_INDEX = 8'h00,
    parameter logic [15:0] RAM_TOP   = 16'h8000,
    parameter logic [15:0] PTR_BASE  = 16'h002A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic [15:0] dma_addr,
    output logic [7:0]  dma_din,
    output logic        dma_we,
    input  logic        dma_ready,
    output logic        busy,
    output logic [15:0] load_end,
    output logic        overflow
);

    state_t      state, state_n, ret_state, ret_n;
    logic [15:0] ptr, ptr_n, load_end_n;
    logic        ovf_n;
    logic        issue;
    logic [15:0] issue_addr;
    logic [7:0]  issue_data;
    logic        slot_idle;
`ifdef PRG_AUTORUN_EN
    logic [2:0]  auto_idx, auto_idx_n;
`endif

    dma_write_slot u_slot (
        .clk        (clk),
        .reset      (reset),
        .issue      (issue),
        .issue_addr (issue_addr),
        .issue_data (issue_data),
        .dma_ready  (dma_ready),
        .dma_addr   (dma_addr),
        .dma_din    (dma_din),
        .dma_we     (dma_we),
        .idle       (slot_idle)
    );

    // hps_io is stalled for exactly as long as a write sits in the slot.
    assign ioctl_wait = !slot_idle;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ret_state <= ST_IDLE;
            ptr       <= 16'h0000;
            load_end  <= 16'h0000;
            overflow  <= 1'b0;
`ifdef PRG_AUTORUN_EN
            auto_idx  <= 3'd0;
`endif
        end else begin
            state     <= state_n;
            ret_state <= ret_n;
            ptr       <= ptr_n;
            load_end  <= load_end_n;
            overflow  <= ovf_n;
`ifdef PRG_AUTORUN_EN
            auto_idx  <= auto_idx_n;
`endif
        end
    end

    always_comb begin
        state_n    = state;
        ret_n      = ret_state;
        ptr_n      = ptr;
        load_end_n = load_end;
        ovf_n      = overflow;
        issue      = 1'b0;
        issue_addr = ptr;
        issue_data = ioctl_dout;
`ifdef PRG_AUTORUN_EN
        auto_idx_n = auto_idx;
`endif
        // A strobe while stalled has nowhere to go.
        if (ioctl_wr && ioctl_wait)
            ovf_n = 1'b1;

        case (state)
            ST_IDLE: begin
                if (ioctl_download) begin
                    if (ioctl_index == PRG_INDEX) begin
                        state_n = ST_PRG_HDR;
                        ovf_n   = 1'b0;
                    end else if (ioctl_index == ROM_INDEX) begin
                        state_n = ST_ROM_DATA;
                        ovf_n   = 1'b0;
                    end
                end
            end
            ST_PRG_HDR: begin
                if (!ioctl_download) begin
                    state_n = ST_DONE;
                end else if (ioctl_wr) begin
                    if (ioctl_addr == 25'd0) begin
                        ptr_n[7:0] = ioctl_dout;
                    end else if (ioctl_addr == 25'd1) begin
                        ptr_n[15:8] = ioctl_dout;
                        state_n     = ST_PRG_DATA;
                    end
                end
            end
            ST_PRG_DATA: begin
                if (!ioctl_download) begin
                    state_n = ST_FIX_LO;
                end else if (ioctl_wr) begin
                    if (ptr < RAM_TOP) begin
                        issue   = 1'b1;
                        ptr_n   = ptr + 16'd1;
                        ret_n   = ST_PRG_DATA;
                        state_n = ST_WR_PEND;
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            ST_ROM_DATA: begin
                if (!ioctl_download) begin
                    state_n = ST_DONE;
                end else if (ioctl_wr && ioctl_addr >= ROM_LO && ioctl_addr < ROM_HI) begin
                    issue      = 1'b1;
                    issue_addr = ioctl_addr[15:0] + ROM_OFS;
                    ret_n      = ST_ROM_DATA;
                    state_n    = ST_WR_PEND;
                end
            end
            ST_WR_PEND: begin
                if (dma_ready)
                    state_n = ret_state;
            end
            ST_FIX_LO: begin
                issue      = 1'b1;
                issue_addr = PTR_BASE;
                issue_data = ptr[7:0];
                ret_n      = ST_FIX_HI;
                state_n    = ST_WR_PEND;
            end
            ST_FIX_HI: begin
                issue      = 1'b1;
                issue_addr = PTR_BASE + 16'd1;
                issue_data = ptr[15:8];
                load_end_n = ptr;
                state_n    = ST_WR_PEND;
`ifdef PRG_AUTORUN_EN
                ret_n      = ST_AUTORUN;
                auto_idx_n = 3'd0;
`else
                ret_n      = ST_DONE;
`endif
            end
`ifdef PRG_AUTORUN_EN
            ST_AUTORUN: begin
                issue      = 1'b1;
                state_n    = ST_WR_PEND;
                auto_idx_n = auto_idx + 3'd1;
                if (auto_idx < 3'd4) begin
                    issue_addr = KBD_BUF_ADDR + {14'd0, auto_idx[1:0]};
                    issue_data = AUTORUN_STR[auto_idx[1:0]];
                    ret_n      = ST_AUTORUN;
                end else begin
                    issue_addr = KBD_CNT_ADDR;
                    issue_data = KBD_CNT_VAL;
                    ret_n      = ST_DONE;
                end
            end
`endif
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

endmodule
